// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and the default datapath width.
package exec_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Opcode 111 is always illegal; MUL is illegal when the multiplier is not built.
    function automatic logic is_illegal(input logic [2:0] opc, input logic mul_en);
        logic ill;
        case (opc)
            3'b111:  ill = 1'b1;
            3'b110:  ill = ~mul_en;
            default: ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_W bits of the product.
module exec_mul_iter
    import exec_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MUL_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] acc_next_s;

    // Partial-product accumulate and last-iteration detect; product is the post-iteration value.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        done    = run && (cnt_r == CNT_W'(MUL_CYCLES - 1));
        product = acc_next_s;
    end

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (start) begin
            mcand_r  <= op_a;
            mplier_r <= op_b;
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (run) begin
            mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops plus optional iterative MUL with a valid/ready result handshake.
// Define EXEC_MUL_EN to build the multiplier; otherwise opcode 110 reports illegal.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MUL_CYCLES = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              dst_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              wr,
    output logic              seti,
    output logic              zero,
    output logic              err
);

`ifdef EXEC_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0 & (MUL_CYCLES > 0);
`endif

    state_e            state_r;
    state_e            state_nxt_s;
    op_e               op_s;
    logic              accept_s;
    logic              start_mul_s;
    logic              illegal_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] res_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_product_s;
    logic [DATA_W-1:0] result_r;
    logic              zero_r;
    logic              err_r;
    logic              seti_r;

    assign op_s        = op_e'(op);
    assign accept_s    = (state_r == IDLE) && in_valid;
    assign illegal_s   = is_illegal(op, MUL_EN);
    assign start_mul_s = accept_s && (op_s == OP_MUL) && MUL_EN;

`ifdef EXEC_MUL_EN
    exec_mul_iter #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_mul_s),
        .run     (state_r == MUL),
        .op_a    (op_a),
        .op_b    (op_b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`else
    assign mul_done_s    = 1'b0;
    assign mul_product_s = {DATA_W{1'b0}};
`endif

    // Single-cycle ALU result; illegal opcodes force zero.
    always_comb begin
        alu_s = {DATA_W{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = op_a + op_b;
            OP_SUB:  alu_s = op_a - op_b;
            OP_AND:  alu_s = op_a & op_b;
            OP_OR:   alu_s = op_a | op_b;
            OP_XOR:  alu_s = op_a ^ op_b;
            OP_SLT:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_s = {DATA_W{1'b0}};
        endcase
        if (illegal_s) begin
            res_s = {DATA_W{1'b0}};
        end else begin
            res_s = alu_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; leaving DONE always passes through IDLE, so no back-to-back accept.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_mul_s) begin
                    state_nxt_s = MUL;
                end else if (accept_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the registered state.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
        wr        = (state_r == DONE) && out_ready;
    end

    // Result registers: loaded at accept for ALU ops, at the final iteration for MUL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
            seti_r   <= 1'b0;
        end else if (accept_s) begin
            seti_r <= dst_sel;
            if (start_mul_s) begin
                result_r <= {DATA_W{1'b0}};
                zero_r   <= 1'b0;
                err_r    <= 1'b0;
            end else begin
                result_r <= res_s;
                zero_r   <= (res_s == {DATA_W{1'b0}});
                err_r    <= illegal_s;
            end
        end else if (mul_done_s) begin
            result_r <= mul_product_s;
            zero_r   <= (mul_product_s == {DATA_W{1'b0}});
            err_r    <= 1'b0;
        end
    end

    assign result = result_r;
    assign zero   = zero_r;
    assign err    = err_r;
    assign seti   = seti_r;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: random and directed requests against an arithmetic reference model.
`timescale 1ns/1ps
module tb_exec_stage;
    import exec_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  op_a = 32'h0;
    logic [W-1:0]  op_b = 32'h0;
    logic          dst_sel = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          wr;
    logic          seti;
    logic          zero;
    logic          err;

    always #5 clk = ~clk;

    exec_stage #(.DATA_W(W), .MUL_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b), .dst_sel(dst_sel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .wr(wr), .seti(seti), .zero(zero), .err(err)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        e;
        logic        s;
        int          acyc;
        int          vcyc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   or_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready policy: 0 always ready, 1 random, 2 stalled
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the opcode table; latency in cycles after accept.
    function automatic exp_t ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic s, input int acc_cyc);
        exp_t x;
        logic [63:0] p;
        int lat;
        lat = 1;
        x.e = 1'b0;
        x.res = 32'h0;
        case (o)
            3'd0: x.res = a + b;
            3'd1: x.res = a - b;
            3'd2: x.res = a & b;
            3'd3: x.res = a | b;
            3'd4: x.res = a ^ b;
            3'd5: x.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: begin
`ifdef EXEC_MUL_EN
                p = {32'h0, a} * {32'h0, b};
                x.res = p[31:0];
                lat = 33;
`else
                x.res = 32'h0;
                x.e = 1'b1;
`endif
            end
            default: begin
                x.res = 32'h0;
                x.e = 1'b1;
            end
        endcase
        x.z = (x.res == 32'h0);
        x.s = s;
        x.acyc = acc_cyc;
        x.vcyc = acc_cyc + lat - 1;
        return x;
    endfunction

    // Monitor: compare DUT handshake and payload against the model's view of the outstanding request.
    always @(negedge clk) begin
        logic busy_m;
        logic vld_m;
        busy_m = 1'b0;
        vld_m = 1'b0;
        if (reset) begin
            if (q.size() != 0) begin
                busy_m = (cyc >= q[0].acyc);
                vld_m = busy_m && (cyc >= q[0].vcyc);
            end
            check("in_ready", 32'(in_ready), 32'(!busy_m));
            check("out_valid", 32'(out_valid), 32'(vld_m));
            check("wr", 32'(wr), 32'(vld_m && out_ready));
            if (vld_m && out_valid) begin
                check("result", result, q[0].res);
                check("zero", 32'(zero), 32'(q[0].z));
                check("err", 32'(err), 32'(q[0].e));
                check("seti", 32'(seti), 32'(q[0].s));
            end
            if (vld_m && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Between accept and completion drive garbage that the DUT must ignore.
    task automatic drive_idle();
        if (q.size() != 0) begin
            in_valid = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            op_a = $urandom;
            op_b = $urandom;
            dst_sel = 1'($urandom_range(0, 1));
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            step();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            drive_idle();
            step();
            guard++;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL completion_timeout: actual pending %0d, required 0", q.size());
            q.delete();
        end
        in_valid = 1'b1;
        op = o;
        op_a = a;
        op_b = b;
        dst_sel = s;
        q.push_back(ref_op(o, a, b, s, cyc + 1));
        step();
        drive_idle();
    endtask

    task automatic reset_mid_op();
        or_mode = 2;
`ifdef EXEC_MUL_EN
        issue(3'b110, 32'd567, 32'd1000, 1'b1);
`else
        issue(3'b000, 32'd11, 32'd22, 1'b1);
`endif
        idle_cycles(9);
        reset = 1'b0;
        #1;
        q.delete();
        in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_seti", 32'(seti), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        @(negedge clk);
        reset = 1'b1;
        or_mode = 0;
        idle_cycles(40);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_result", result, 32'd0);
        check("init_zero", 32'(zero), 32'd0);
        check("init_err", 32'(err), 32'd0);
        check("init_seti", 32'(seti), 32'd0);
        check("init_wr", 32'(wr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        or_mode = 0;
        issue(3'b000, 32'd567, 32'd33, 1'b1);
        issue(3'b001, 32'd5, 32'd5, 1'b0);
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(3'b101, 32'd1, 32'hFFFF_FFFF, 1'b0);
        issue(3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
        issue(3'b011, 32'hF000_0000, 32'h0000_000F, 1'b0);
        issue(3'b100, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1);
        issue(3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(3'b110, 32'd567, 32'd1000, 1'b1);
        issue(3'b111, 32'd7, 32'd9, 1'b1);

        or_mode = 2;
        issue(3'b000, 32'd100, 32'd200, 1'b1);
        idle_cycles(5);
        or_mode = 0;
        idle_cycles(3);

        reset_mid_op();

        or_mode = 1;
        for (int i = 0; i < 250; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end
        or_mode = 0;
        idle_cycles(60);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: actual pending %0d, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
